buf_addr_sched: RTL

Buffer address scheduler for the 4096×134 packet RAM in the data controller. Partitions the RAM into fixed 128-word blocks and keeps a free list of block IDs. Grants one block per incoming packet and drives the write base address. Queues completed packets in arrival order, issues their read base addresses when the egress side is ready, and returns each block to the free list once the packet tail has been read out.

---
 rtl/buf_addr_sched_pkg.sv | 23 ++
 rtl/buf_addr_sched_if.sv | 34 +++
 rtl/buf_addr_sched_blk_id_fifo.sv | 66 ++++++
 rtl/buf_addr_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/buf_addr_sched_pkg.sv
// buf_sched_pkg: shared constants for the buffer address scheduler.
// Holds the RAM partitioning parameters, the write/read FSM state encodings
// and the read-watchdog limit used when RD_TIMEOUT_EN is defined.
package buf_sched_pkg;

  localparam int BLK_NUM        = 32;   // buffer blocks in the packet RAM
  localparam int BLK_W          = 5;    // block ID width
  localparam int BLK_WORDS_W    = 7;    // log2 words per block
  localparam int ADDR_W         = 12;   // RAM word address width
  localparam int CNT_W          = 6;    // occupancy counters, 0..BLK_NUM
  localparam int RD_TIMEOUT_CYC = 1023; // read watchdog limit in cycles

  // Write FSM
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_W_IDLE = 2'd1;
  localparam logic [1:0] ST_W_BUSY = 2'd2;

  // Read FSM
  localparam logic [1:0] ST_R_IDLE  = 2'd0;
  localparam logic [1:0] ST_R_ISSUE = 2'd1;
  localparam logic [1:0] ST_R_WAIT  = 2'd2;

endpackage

// File: rtl/buf_addr_sched_if.sv
// buf_addr_sched_if: handshake/bus bundle between the scheduler and the
// ibm / ebm / data controller.
//   master : ibm/ebm/data-controller side (drives requests, reads addresses)
//   slave  : scheduler side
interface buf_addr_sched_if;
  import buf_sched_pkg::*;

  logic              in_alloc_req;
  logic              in_pkt_done;
  logic              out_buf_full;
  logic [ADDR_W-1:0] addr2data_waddr;
  logic              addr2data_waddr_wr;
  logic              in_ebm_ready;
  logic [ADDR_W-1:0] addr2data_raddr;
  logic              addr2data_raddr_wr;
  logic              in_data_cache_valid;
  logic [CNT_W-1:0]  out_free_cnt;
  logic [CNT_W-1:0]  out_txq_cnt;
  logic              out_err;

  modport master (
    output in_alloc_req, in_pkt_done, in_ebm_ready, in_data_cache_valid,
    input  out_buf_full, addr2data_waddr, addr2data_waddr_wr,
           addr2data_raddr, addr2data_raddr_wr, out_free_cnt, out_txq_cnt,
           out_err
  );

  modport slave (
    input  in_alloc_req, in_pkt_done, in_ebm_ready, in_data_cache_valid,
    output out_buf_full, addr2data_waddr, addr2data_waddr_wr,
           addr2data_raddr, addr2data_raddr_wr, out_free_cnt, out_txq_cnt,
           out_err
  );
endinterface

// File: rtl/buf_addr_sched_blk_id_fifo.sv
// blk_id_fifo: synchronous first-word-fall-through FIFO of block IDs.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (pointers/count only)
//   push, push_data write one entry (ignored when full)
//   pop             consume head entry (ignored when empty)
//   pop_data        current head entry
//   empty           no entries
//   count           registered occupancy, 0..DEPTH
module blk_id_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Both instances are sized to hold every block, so a push into a full
  // FIFO means a block ID was duplicated somewhere upstream.
  push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/buf_addr_sched.sv
// buf_addr_sched: buffer address scheduler for the 4096x134 packet RAM.
// Splits the RAM into 128-word blocks, hands one free block to each new
// packet, queues finished packets in arrival order and returns each block to
// the free list once its tail has been read out.
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset
//   bus    buf_addr_sched_if.slave: alloc/done from ibm, write/read base
//          addresses and strobes, ebm ready, tail marker, counters, error
// Build option: RD_TIMEOUT_EN adds a 10-bit watchdog in R_WAIT that releases
// the block and flags an error if the tail marker never arrives.
module buf_addr_sched
  import buf_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  buf_addr_sched_if.slave  bus
);

  logic [1:0]        wstate_q, wstate_d;
  logic [1:0]        rstate_q, rstate_d;
  logic [BLK_W-1:0]  init_cnt_q, init_cnt_d;
  logic [BLK_W-1:0]  cur_wid_q, cur_wid_d;
  logic [BLK_W-1:0]  cur_rid_q, cur_rid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              waddr_wr_q, waddr_wr_d;
  logic              raddr_wr_q, raddr_wr_d;
  logic              err_q, err_d;
`ifdef RD_TIMEOUT_EN
  logic [9:0]        tmo_cnt_q, tmo_cnt_d;
`endif

  logic              init_push, rel_push, rd_tmo, werr;
  logic              free_push, free_pop, free_empty;
  logic [BLK_W-1:0]  free_din, free_dout;
  logic [CNT_W-1:0]  free_cnt;
  logic              txq_push, txq_pop, txq_empty;
  logic [BLK_W-1:0]  txq_dout;
  logic [CNT_W-1:0]  txq_cnt;

  // INIT and release never coincide: the txq is empty during INIT.
  assign free_push = init_push || rel_push;
  assign free_din  = init_push ? init_cnt_q : cur_rid_q;

  blk_id_fifo #(.DATA_W(BLK_W), .DEPTH(BLK_NUM), .CNT_W(CNT_W)) u_free_fifo (
    .clk(clk), .rst_n(rst_n), .push(free_push), .push_data(free_din),
    .pop(free_pop), .pop_data(free_dout), .empty(free_empty), .count(free_cnt)
  );

  blk_id_fifo #(.DATA_W(BLK_W), .DEPTH(BLK_NUM), .CNT_W(CNT_W)) u_txq_fifo (
    .clk(clk), .rst_n(rst_n), .push(txq_push), .push_data(cur_wid_q),
    .pop(txq_pop), .pop_data(txq_dout), .empty(txq_empty), .count(txq_cnt)
  );

  // Write side: INIT fill, then grant one block per packet.
  always_comb begin
    wstate_d   = wstate_q;
    init_cnt_d = init_cnt_q;
    cur_wid_d  = cur_wid_q;
    waddr_d    = waddr_q;
    waddr_wr_d = 1'b0;
    init_push  = 1'b0;
    free_pop   = 1'b0;
    txq_push   = 1'b0;
    werr       = 1'b0;
    case (wstate_q)
      ST_INIT: begin
        init_push  = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == BLK_W'(BLK_NUM - 1)) wstate_d = ST_W_IDLE;
        werr = bus.in_alloc_req || bus.in_pkt_done;
      end
      ST_W_IDLE: begin
        if (bus.in_alloc_req) begin
          if (!free_empty) begin
            free_pop   = 1'b1;
            cur_wid_d  = free_dout;
            waddr_d    = {free_dout, {BLK_WORDS_W{1'b0}}};
            waddr_wr_d = 1'b1;
            wstate_d   = ST_W_BUSY;
          end else begin
            werr = 1'b1;
          end
        end
        if (bus.in_pkt_done) werr = 1'b1;
      end
      ST_W_BUSY: begin
        if (bus.in_alloc_req) werr = 1'b1;
        if (bus.in_pkt_done) begin
          txq_push = 1'b1;
          wstate_d = ST_W_IDLE;
        end
      end
      default: wstate_d = ST_INIT;
    endcase
  end

  // Read side: one outstanding read at a time.
  always_comb begin
    rstate_d   = rstate_q;
    cur_rid_d  = cur_rid_q;
    raddr_d    = raddr_q;
    raddr_wr_d = 1'b0;
    txq_pop    = 1'b0;
    rel_push   = 1'b0;
    rd_tmo     = 1'b0;
`ifdef RD_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (rstate_q)
      ST_R_IDLE: begin
        if (!txq_empty && bus.in_ebm_ready) begin
          txq_pop   = 1'b1;
          cur_rid_d = txq_dout;
          rstate_d  = ST_R_ISSUE;
        end
      end
      ST_R_ISSUE: begin
        raddr_d    = {cur_rid_q, {BLK_WORDS_W{1'b0}}};
        raddr_wr_d = 1'b1;
        rstate_d   = ST_R_WAIT;
`ifdef RD_TIMEOUT_EN
        tmo_cnt_d  = '0;
`endif
      end
      ST_R_WAIT: begin
        if (bus.in_data_cache_valid) begin
          rel_push = 1'b1;
          rstate_d = ST_R_IDLE;
        end
`ifdef RD_TIMEOUT_EN
        // Counter is 0 in the strobe cycle, so firing at LIMIT-1 lands the
        // error pulse exactly LIMIT cycles after raddr_wr.
        else if (tmo_cnt_q == 10'(RD_TIMEOUT_CYC - 1)) begin
          rel_push = 1'b1;
          rd_tmo   = 1'b1;
          rstate_d = ST_R_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: rstate_d = ST_R_IDLE;
    endcase
  end

  assign err_d = werr || rd_tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q   <= ST_INIT;
      rstate_q   <= ST_R_IDLE;
      init_cnt_q <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      waddr_wr_q <= 1'b0;
      raddr_wr_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef RD_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      init_cnt_q <= init_cnt_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      waddr_wr_q <= waddr_wr_d;
      raddr_wr_q <= raddr_wr_d;
      err_q      <= err_d;
`ifdef RD_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    cur_wid_q <= cur_wid_d;
    cur_rid_q <= cur_rid_d;
  end

  assign bus.out_buf_full       = (wstate_q == ST_INIT) || free_empty;
  assign bus.addr2data_waddr    = waddr_q;
  assign bus.addr2data_waddr_wr = waddr_wr_q;
  assign bus.addr2data_raddr    = raddr_q;
  assign bus.addr2data_raddr_wr = raddr_wr_q;
  assign bus.out_free_cnt       = free_cnt;
  assign bus.out_txq_cnt        = txq_cnt;
  assign bus.out_err            = err_q;

endmodule
